sample_iterator: RTL



---
 rtl/sample_iterator.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sample_iterator.sv
// sample_iterator: walks a triangle's bounding box in raster order (x fastest)
// at the selected subsample pitch, emitting SAMPS horizontally adjacent sample
// locations per cycle with per-sample valid flags.
// Optional build macro: SAMPLE_ITER_PERF_EN adds a 32-bit consumed-group counter.
module sample_iterator #(
   parameter int SIGFIG = 24,
   parameter int RADIX  = 10,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3,
   parameter int COLORS = 3,
   parameter int SAMPS  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
   input  logic        [SIGFIG-1:0] color_R13U [COLORS],
   input  logic signed [SIGFIG-1:0] box_R13S [2][2],
   input  logic                     validTri_R13H,
   input  logic        [3:0]        subSample_RnnnnU,
   input  logic                     halt_R14H,
   output logic                     halt_R13H,
   output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
   output logic        [SIGFIG-1:0] color_R14U [COLORS],
   output logic signed [SIGFIG-1:0] sample_R14S [2][SAMPS],
`ifdef SAMPLE_ITER_PERF_EN
   output logic        [31:0]       groupCnt_R14U,
`endif
   output logic        [SAMPS-1:0]  validSamp_R14H
);

   // One guard bit so that stepping past the right edge never wraps.
   localparam int GW = SIGFIG + 1;

   typedef enum logic {WAIT, TEST} state_t;

   state_t                   state, next_state;
   logic                     accept, advance, wrap, consume;
   int                       shift_k;
   logic        [SIGFIG-1:0] step, mask;
   logic signed [SIGFIG-1:0] sx0_in, sy0_in;
   logic signed [SIGFIG-1:0] cx, cy, sx0, urx, ury;
   logic signed [GW-1:0]     step_w, cx_w, cy_w, urx_w, ury_w, nx_w, ny_w, acc;
   logic signed [GW-1:0]     xs [SAMPS];

   // Decode the one-hot pitch into a step and the start-point alignment mask.
   always_comb begin
      case (subSample_RnnnnU)
         4'b0100: shift_k = 1;
         4'b0010: shift_k = 2;
         4'b0001: shift_k = 3;
         default: shift_k = 0;
      endcase
      step   = SIGFIG'(1) << (RADIX - shift_k);
      mask   = ~(step - SIGFIG'(1));
      sx0_in = box_R13S[0][0] & mask;
      sy0_in = box_R13S[0][1] & mask;
   end

   // Guard-extended positions of every sample in the current group plus the next group start.
   always_comb begin
      step_w = {1'b0, step};
      cx_w   = {cx[SIGFIG-1], cx};
      cy_w   = {cy[SIGFIG-1], cy};
      urx_w  = {urx[SIGFIG-1], urx};
      ury_w  = {ury[SIGFIG-1], ury};
      acc    = cx_w;
      for (int i = 0; i < SAMPS; i++) begin
         xs[i] = acc;
         acc   = acc + step_w;
      end
      nx_w = acc;
      ny_w = cy_w + step_w;
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst) state <= WAIT;
      else      state <= next_state;
   end

   // Next-state and control decode.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      next_state = state;
      halt_R13H  = 1'b0;
      accept     = 1'b0;
      advance    = 1'b0;
      wrap       = 1'b0;
      consume    = 1'b0;
      case (state)
         WAIT: begin
            if (validTri_R13H) begin
               accept = 1'b1;
               if ((box_R13S[1][0] >= sx0_in) && (box_R13S[1][1] >= sy0_in))
                  next_state = TEST;
            end
         end
         TEST: begin
            halt_R13H = 1'b1;
            if (!halt_R14H) begin
               consume = 1'b1;
               if (nx_w <= urx_w)      advance    = 1'b1;
               else if (ny_w <= ury_w) wrap       = 1'b1;
               else                    next_state = WAIT;
            end
         end
         default: next_state = WAIT;
      endcase
   end

   // Triangle latch and raster position registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cx  <= '0;
         cy  <= '0;
         sx0 <= '0;
         urx <= '0;
         ury <= '0;
         // NOTE: these are small register arrays, not RAM, so they are reset to give defined outputs.
         for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
               tri_R14S[v][a] <= '0;
         for (int c = 0; c < COLORS; c++)
            color_R14U[c] <= '0;
      end else if (accept) begin
         cx  <= sx0_in;
         cy  <= sy0_in;
         sx0 <= sx0_in;
         urx <= box_R13S[1][0];
         ury <= box_R13S[1][1];
         tri_R14S   <= tri_R13S;
         color_R14U <= color_R13U;
      end else if (advance) begin
         cx <= nx_w[SIGFIG-1:0];
      end else if (wrap) begin
         cx <= sx0;
         cy <= ny_w[SIGFIG-1:0];
      end
   end

   // Sample outputs: the current group in TEST, all zero with no valids in WAIT.
   always_comb begin
      validSamp_R14H = '0;
      for (int i = 0; i < SAMPS; i++) begin
         sample_R14S[0][i] = '0;
         sample_R14S[1][i] = '0;
      end
      if (state == TEST) begin
         for (int i = 0; i < SAMPS; i++) begin
            sample_R14S[0][i] = xs[i][SIGFIG-1:0];
            sample_R14S[1][i] = cy;
            validSamp_R14H[i] = (xs[i] <= urx_w);
         end
      end
   end

`ifdef SAMPLE_ITER_PERF_EN
   // Count groups handed downstream; wraps naturally at 2^32.
   always_ff @(posedge clk) begin
      if (!rst)         groupCnt_R14U <= '0;
      else if (consume) groupCnt_R14U <= groupCnt_R14U + 32'd1;
   end
`endif

endmodule
